regfile_mp: RTL and testbench

- Parametrised two-read, one-write register file for the instruction-driven datapath.
- Successor to the streaming-load operand register file.
- Operands are preloaded by a sequential data stream. Two source operands are read using fields decoded from the instruction word.
- Adds a datapath write-back port, write-to-read forwarding, an optional hardwired zero register, an enable-driven stall, and collision reporting.

---
 rtl/regfile_mp.sv | 154 +++++++++++++++
 tb/tb_regfile_mp.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: two-read, one-write register file with a streaming load path,
// an unregistered write-back port, write-first forwarding into the read
// pipeline, an optional hardwired zero register and sticky collision flag.
module regfile_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 5,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned SRC1_LSB   = 6,
  parameter int unsigned SRC2_LSB   = 1,
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [INST_WIDTH-1:0] inst,
  input  logic                  inst_valid,
  input  logic                  wb_valid,
  input  logic [ADDR_BITS-1:0]  wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] src1,
  output logic [DATA_WIDTH-1:0] src2,
  output logic                  src_valid,
  output logic [ADDR_BITS:0]    load_count,
  output logic                  wb_collision
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CNT_W = ADDR_BITS + 1;
  localparam bit          ZR    = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Load stage and read-address stage registers
  logic                  load_v_q;
  logic [DATA_WIDTH-1:0] load_d_q;
  logic [ADDR_BITS-1:0]  load_ptr;
  logic                  inst_v_q;
  logic [ADDR_BITS-1:0]  rd_addr1_q;
  logic [ADDR_BITS-1:0]  rd_addr2_q;

  // Combinational write-port selection and read results
  logic                  wb_req_c;
  logic                  collide_c;
  logic                  wr_en_c;
  logic [ADDR_BITS-1:0]  wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic                  load_busy_c;
  logic                  src_valid_c;
  logic [DATA_WIDTH-1:0] rd1_c;
  logic [DATA_WIDTH-1:0] rd2_c;
  logic                  unused_inst_c;

  // Address 0 is hardwired only when the zero register is enabled
  function automatic logic is_zero(input logic [ADDR_BITS-1:0] a);
    return ZR && (a == '0);
  endfunction

  // Bits of inst outside the two address fields carry no meaning here
  assign unused_inst_c = ^inst;

  // Pick the single committing write: registered load beats write-back
  always_comb begin
    wb_req_c  = wb_valid && !is_zero(wb_addr);
    collide_c = wb_req_c && load_v_q;
    wr_en_c   = 1'b0;
    wr_addr_c = wb_addr;
    wr_data_c = wb_data;
    if (load_v_q) begin
      wr_en_c   = !is_zero(load_ptr);
      wr_addr_c = load_ptr;
      wr_data_c = load_d_q;
    end else if (wb_req_c) begin
      wr_en_c   = 1'b1;
    end
  end

  // Array read with write-first forwarding of the write committing this edge
  always_comb begin
    rd1_c = mem[rd_addr1_q];
    rd2_c = mem[rd_addr2_q];
    if (wr_en_c && (wr_addr_c == rd_addr1_q)) rd1_c = wr_data_c;
    if (wr_en_c && (wr_addr_c == rd_addr2_q)) rd2_c = wr_data_c;
    if (is_zero(rd_addr1_q)) rd1_c = '0;
    if (is_zero(rd_addr2_q)) rd2_c = '0;
  end

  // Operands are only valid when no load word is pending or being written
  always_comb begin
    load_busy_c = load_valid || load_v_q;
    src_valid_c = inst_v_q && !load_busy_c;
  end

  // Storage array; contents are not reset
  always_ff @(posedge clk) begin
    if (rst_n && en && wr_en_c) begin
      mem[wr_addr_c] <= wr_data_c;
    end
  end

  // Load pointer, burst counter and load staging register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_v_q   <= 1'b0;
      load_d_q   <= '0;
      load_ptr   <= '0;
      load_count <= '0;
    end else if (en) begin
      load_v_q <= load_valid;
      load_d_q <= load_data;
      if (load_v_q) begin
        load_ptr <= load_ptr + ADDR_BITS'(1);
        if (load_count != CNT_W'(DEPTH)) begin
          load_count <= load_count + CNT_W'(1);
        end
      end else begin
        load_ptr   <= '0;
        load_count <= '0;
      end
    end
  end

  // Read pipeline: address capture, then registered operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_v_q   <= 1'b0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      src_valid  <= 1'b0;
      src1       <= '0;
      src2       <= '0;
    end else if (en) begin
      inst_v_q   <= inst_valid;
      rd_addr1_q <= inst[SRC1_LSB +: ADDR_BITS];
      rd_addr2_q <= inst[SRC2_LSB +: ADDR_BITS];
      src_valid  <= src_valid_c;
      if (src_valid_c) begin
        src1 <= rd1_c;
        src2 <= rd2_c;
      end
    end
  end

  // Sticky record of any write-back dropped in favour of a load write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_collision <= 1'b0;
    end else if (en && collide_c) begin
      wb_collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a plain-arithmetic model of the register file drives
// a per-cycle compare, and directed sequences pin specific literal values.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AB    = 5;
  localparam int IW    = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic [IW-1:0] inst = '0;
  logic          inst_valid = 1'b0;
  logic          wb_valid = 1'b0;
  logic [AB-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;

  // Index 0: ZERO_REG=0 instance, index 1: ZERO_REG=1 instance
  logic [DW-1:0] o_src1 [2];
  logic [DW-1:0] o_src2 [2];
  logic          o_sv   [2];
  logic [AB:0]   o_cnt  [2];
  logic          o_coll [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.ZERO_REG(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load_valid(load_valid), .load_data(load_data),
    .inst(inst), .inst_valid(inst_valid), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .src1(o_src1[0]), .src2(o_src2[0]), .src_valid(o_sv[0]),
    .load_count(o_cnt[0]), .wb_collision(o_coll[0]));

  regfile_mp #(.ZERO_REG(1)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .en(en), .load_valid(load_valid), .load_data(load_data),
    .inst(inst), .inst_valid(inst_valid), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .src1(o_src1[1]), .src2(o_src2[1]), .src_valid(o_sv[1]),
    .load_count(o_cnt[1]), .wb_collision(o_coll[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem   [2][DEPTH];
  bit            m_known [2][DEPTH];
  bit            m_lv;
  logic [DW-1:0] m_ld;
  int            m_ptr, m_cnt;
  bit            m_iv;
  int            m_a1, m_a2;
  bit            m_sv;
  logic [DW-1:0] m_s1 [2];
  logic [DW-1:0] m_s2 [2];
  bit            m_k1 [2];
  bit            m_k2 [2];
  bit            m_coll [2];

  task automatic model_reset();
    m_lv = 0; m_ld = '0; m_ptr = 0; m_cnt = 0; m_iv = 0; m_a1 = 0; m_a2 = 0; m_sv = 0;
    for (int z = 0; z < 2; z++) begin
      m_s1[z] = '0; m_s2[z] = '0; m_k1[z] = 1; m_k2[z] = 1; m_coll[z] = 0;
    end
  endtask

  task automatic model_store(input int z, input int a, input logic [DW-1:0] d);
    if (!(z == 1 && a == 0)) begin
      m_mem[z][a]   = d;
      m_known[z][a] = 1;
    end
  endtask

  // Writes of this edge land first, then reads see the updated contents
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else if (en) begin
      bit busy;
      busy = load_valid || m_lv;
      for (int z = 0; z < 2; z++) begin
        bit wb_live;
        wb_live = wb_valid && !(z == 1 && wb_addr == 0);
        if (m_lv) begin
          model_store(z, m_ptr, m_ld);
          if (wb_live) m_coll[z] = 1;
        end else if (wb_live) begin
          model_store(z, int'(wb_addr), wb_data);
        end
        if (m_iv && !busy) begin
          m_s1[z] = (z == 1 && m_a1 == 0) ? '0 : m_mem[z][m_a1];
          m_k1[z] = (z == 1 && m_a1 == 0) || m_known[z][m_a1];
          m_s2[z] = (z == 1 && m_a2 == 0) ? '0 : m_mem[z][m_a2];
          m_k2[z] = (z == 1 && m_a2 == 0) || m_known[z][m_a2];
        end
      end
      m_sv  = m_iv && !busy;
      m_cnt = m_lv ? ((m_cnt < DEPTH) ? m_cnt + 1 : DEPTH) : 0;
      m_ptr = m_lv ? (m_ptr + 1) % DEPTH : 0;
      m_lv  = load_valid;
      m_ld  = load_data;
      m_iv  = inst_valid;
      m_a1  = int'(inst[10:6]);
      m_a2  = int'(inst[5:1]);
    end
  end

  // Per-cycle compare of both instances against the model
  always @(negedge clk) begin
    for (int z = 0; z < 2; z++) begin
      chk($sformatf("src_valid[%0d]", z), 64'(o_sv[z]), 64'(m_sv));
      chk($sformatf("load_count[%0d]", z), 64'(o_cnt[z]), 64'(m_cnt));
      chk($sformatf("wb_collision[%0d]", z), 64'(o_coll[z]), 64'(m_coll[z]));
      if (m_k1[z]) chk($sformatf("src1[%0d]", z), 64'(o_src1[z]), 64'(m_s1[z]));
      if (m_k2[z]) chk($sformatf("src2[%0d]", z), 64'(o_src2[z]), 64'(m_s2[z]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [IW-1:0] build(input int a1, input int a2);
    logic [IW-1:0] r;
    r = '0;
    r[10:6] = a1[4:0];
    r[5:1]  = a2[4:0];
    return r;
  endfunction

  // Issue one read and stop at the cycle the operands appear
  task automatic do_read(input int a1, input int a2);
    inst = build(a1, a2);
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_src_valid", 64'(o_sv[0]), 64'd0);
    chk("reset_load_count", 64'(o_cnt[0]), 64'd0);
    chk("reset_src1", 64'(o_src1[0]), 64'd0);
    chk("reset_coll", 64'(o_coll[0]), 64'd0);

    // Full 32-word burst, counter saturates then clears
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h100 + 32'(i);
      tick();
      chk("burst_count", 64'(o_cnt[0]), 64'(i));
    end
    load_valid = 1'b0;
    tick();
    chk("burst_count_sat", 64'(o_cnt[0]), 64'd32);
    tick();
    chk("burst_count_clr", 64'(o_cnt[0]), 64'd0);

    inst = build(5, 31);
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    chk("lat_sv_t1", 64'(o_sv[0]), 64'd0);
    tick();
    chk("lat_sv_t2", 64'(o_sv[0]), 64'd1);
    chk("read_src1", 64'(o_src1[0]), 64'h105);
    chk("read_src2", 64'(o_src2[0]), 64'h11F);
    tick();
    chk("sv_pulse", 64'(o_sv[0]), 64'd0);

    // Write-back forwarded into an in-flight read of the same address
    inst = build(7, 7);
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    wb_valid = 1'b1;
    wb_addr  = 5'd7;
    wb_data  = 32'hDEADBEEF;
    tick();
    wb_valid = 1'b0;
    chk("fwd_src1", 64'(o_src1[0]), 64'hDEADBEEF);
    chk("fwd_src2", 64'(o_src2[0]), 64'hDEADBEEF);

    // Write-back during a load is dropped and flagged
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h200 + 32'(i);
      wb_valid   = (i == 4);
      wb_addr    = 5'd3;
      wb_data    = 32'h0BAD;
      tick();
    end
    load_valid = 1'b0;
    wb_valid   = 1'b0;
    tick();
    chk("coll_set", 64'(o_coll[0]), 64'd1);
    repeat (100) tick();
    chk("coll_sticky", 64'(o_coll[0]), 64'd1);
    chk("coll_sticky_z", 64'(o_coll[1]), 64'd1);
    do_read(3, 3);
    chk("coll_load_wins", 64'(o_src1[0]), 64'h203);

    // Asynchronous reset between edges in the middle of a burst
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h400 + 32'(i);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sv", 64'(o_sv[0]), 64'd0);
    chk("arst_count", 64'(o_cnt[0]), 64'd0);
    chk("arst_coll", 64'(o_coll[0]), 64'd0);
    chk("arst_src1", 64'(o_src1[0]), 64'd0);
    chk("arst_src2", 64'(o_src2[0]), 64'd0);
    load_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h500 + 32'(i);
      tick();
    end
    load_valid = 1'b0;
    repeat (2) tick();
    do_read(0, 2);
    chk("arst_new_a0", 64'(o_src1[0]), 64'h500);
    chk("arst_new_a2", 64'(o_src2[0]), 64'h502);
    chk("arst_new_a0_z", 64'(o_src1[1]), 64'd0);

    // Zero register: load and write-back to address 0 are discarded
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = (i == 0) ? 32'hAAAA : 32'hBBBB;
      wb_valid   = (i == 1);
      wb_addr    = 5'd0;
      wb_data    = 32'h5555;
      tick();
    end
    load_valid = 1'b0;
    wb_valid   = 1'b0;
    repeat (2) tick();
    wb_valid = 1'b1;
    wb_addr  = 5'd0;
    wb_data  = 32'h1234;
    tick();
    wb_valid = 1'b0;
    do_read(0, 0);
    chk("zero_src1_z", 64'(o_src1[1]), 64'd0);
    chk("zero_src2_z", 64'(o_src2[1]), 64'd0);
    chk("zero_coll_z", 64'(o_coll[1]), 64'd0);
    chk("nozero_src1", 64'(o_src1[0]), 64'h1234);
    chk("nozero_coll", 64'(o_coll[0]), 64'd1);

    // Stall mid-burst: nothing advances and no word is lost or duplicated
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        en = 1'b0;
        load_data = 32'hFFFF_FFFF;
        repeat (5) begin
          tick();
          chk("stall_count", 64'(o_cnt[0]), 64'd4);
        end
        en = 1'b1;
      end
      load_valid = 1'b1;
      load_data  = 32'h300 + 32'(i);
      tick();
    end
    load_valid = 1'b0;
    repeat (2) tick();
    do_read(5, 9);
    chk("stall_a5", 64'(o_src1[0]), 64'h305);
    chk("stall_a9", 64'(o_src2[0]), 64'h309);
    do_read(4, 6);
    chk("stall_a4", 64'(o_src1[0]), 64'h304);
    chk("stall_a6", 64'(o_src2[0]), 64'h306);

    // Stall with a read in flight
    inst = build(9, 4);
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    en = 1'b0;
    repeat (5) begin
      tick();
      chk("rstall_sv", 64'(o_sv[0]), 64'd0);
      chk("rstall_src1", 64'(o_src1[0]), 64'h304);
    end
    en = 1'b1;
    tick();
    chk("rstall_sv_resume", 64'(o_sv[0]), 64'd1);
    chk("rstall_src1_resume", 64'(o_src1[0]), 64'h309);
    chk("rstall_src2_resume", 64'(o_src2[0]), 64'h304);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
